// File: rtl/key_press_conditioner.sv
// Conditions three raw set keys into one-cycle increment pulses (press + auto-repeat) and debounced levels.
// Latency DEBOUNCE_CYC+2 edges raw->level/press pulse; no backpressure, pulses are fire-and-forget.
module key_press_conditioner #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int REPEAT_DLY   = 1000,
    parameter int REPEAT_PER   = 200,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keyHr,
    input  logic       keyMin,
    input  logic       keySec,
    output logic       incHr,
    output logic       incMin,
    output logic       incSec,
    output logic [2:0] keyLvl
);
    localparam int NCH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_TERM   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_TERM  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_TERM  = CNT_W'(REPEAT_PER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               REPEAT_EN = (REPEAT_DLY != 0);

    logic [NCH-1:0]   key_raw;
    logic [NCH-1:0]   s1_q;
    logic [NCH-1:0]   s2_q;
    logic [NCH-1:0]   db_q;
    logic [NCH-1:0]   db_d;
    logic [NCH-1:0]   db_rise;
    logic [NCH-1:0]   db_fall;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CNT_W-1:0] rc_q  [NCH];
    logic [CNT_W-1:0] rc_d  [NCH];
    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic [NCH-1:0]   inc_q;
    logic [NCH-1:0]   inc_d;

    assign key_raw = {keyHr, keyMin, keySec};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= key_raw;
            s2_q <= s1_q;
        end
    end

    // The level flips on the same edge that the FSM sees the rise/fall event,
    // so the press pulse and keyLvl leave the block in the same cycle.
    always_comb begin
        db_d    = db_q;
        db_rise = '0;
        db_fall = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_TERM) begin
                    db_d[i]    = ~db_q[i];
                    db_rise[i] = ~db_q[i];
                    db_fall[i] = db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        inc_d = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            rc_d[i]    = rc_q[i];
            if (db_fall[i]) begin
                // Release wins over a repeat that happens to be due this cycle.
                state_d[i] = IDLE;
                rc_d[i]    = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        rc_d[i] = '0;
                        if (db_rise[i]) begin
                            state_d[i] = FIRST;
                            inc_d[i]   = 1'b1;
                        end
                    end
                    FIRST: begin
                        if (REPEAT_EN) begin
                            if (rc_q[i] == DLY_TERM) begin
                                state_d[i] = REPEAT;
                                rc_d[i]    = '0;
                                inc_d[i]   = 1'b1;
                            end else begin
                                rc_d[i] = rc_q[i] + CNT_ONE;
                            end
                        end
                    end
                    REPEAT: begin
                        if (rc_q[i] == PER_TERM) begin
                            rc_d[i]  = '0;
                            inc_d[i] = 1'b1;
                        end else begin
                            rc_d[i] = rc_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        rc_d[i]    = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q  <= '0;
            inc_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= '0;
                rc_q[i]    <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            db_q  <= db_d;
            inc_q <= inc_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                rc_q[i]    <= rc_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign {incHr, incMin, incSec} = inc_q;
    assign keyLvl                  = db_q;

endmodule
